fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Owns the program counter at the fetch end of the pipeline. Consumes the EX-stage branch redirect (PcSel/BrPC) and applies it to the PC, and generates IF/ID and ID/EX flushes. Sequences the instruction-memory handshake and drops a fetch already in flight when a redirect arrives mid-access. Sits between the hazard unit, the branch unit outputs and instruction memory.

Parameters:
PC_W, 9, PC width in bits; instruction memory is 2^PC_W bytes.
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
Stall  input  1  hazard-unit stall; hold PC and IF/ID.
PcSel  input  1  branch/jump taken in EX this cycle.
BrPC  input  32  redirect target; valid only when PcSel=1.
ImemReady  input  1  instruction memory completes the access for PC this cycle.
PC  output  PC_W  current fetch address to instruction memory.
ImemReq  output  1  fetch request for PC.
FetchValid  output  1  instruction word at PC is valid for IF/ID this cycle.
IfIdFlush  output  1  clear IF/ID register.
IdExFlush  output  1  clear ID/EX register.
MisalignErr  output  1  sticky; a redirect target had BrPC[1:0] != 0.
RedirectCnt  output  16  saturating count of accepted redirects.

Behaviour:
- Reset (async, immediate): PC=RESET_PC, state=RUN, MisalignErr=0, RedirectCnt=0. Outputs during reset: ImemReq=0, FetchValid=0, IfIdFlush=0, IdExFlush=0.
- Internal state: RUN, DRAIN. Internal register PendPC[PC_W-1:0].
- Target formation: Tgt = {BrPC[PC_W-1:2], 2'b00}. Upper BrPC bits are ignored. If BrPC[1:0] != 0 on an accepted redirect, MisalignErr is set on the next edge and stays set until reset.
- IfIdFlush = IdExFlush = PcSel, combinational, in every state. PcSel has priority over Stall.
- RedirectCnt increments on every cycle with PcSel=1 and saturates at 0xFFFF.
- RUN (ImemReq=1):
  - PcSel=1, ImemReady=1: PC<=Tgt; FetchValid=0; stay in RUN.
  - PcSel=1, ImemReady=0: the in-flight access is stale. PendPC<=Tgt; PC held; FetchValid=0; go to DRAIN.
  - PcSel=0, Stall=1: PC held; FetchValid=0.
  - PcSel=0, Stall=0, ImemReady=1: FetchValid=1; PC<=PC+4, modulo 2^PC_W.
  - PcSel=0, Stall=0, ImemReady=0: PC held; FetchValid=0.
- DRAIN (ImemReq=1, holding the old PC so the memory can finish; FetchValid=0 always):
  - PcSel=1: PendPC<=Tgt (latest redirect wins); flushes asserted.
  - ImemReady=1: PC<=PendPC, or Tgt if PcSel=1 in the same cycle; go to RUN.
  - Stall is ignored in DRAIN.
- Latency: the redirected PC appears one cycle after PcSel when the memory is ready. Otherwise it appears one cycle after the ImemReady that ends DRAIN.
- Wrap-around: with PC_W=9, PC=508 advances to 0.
- Reset asserted in DRAIN drops PendPC; the bench must not expect the pending target after reset.

Test Plan:
- Reset then ImemReady=1 constant, no stalls -> PC sequence 0,4,8,12; FetchValid=1 each cycle; flushes 0.
- PC=0x010, PcSel=1, BrPC=0x0000_0120, ImemReady=1 -> IfIdFlush=IdExFlush=1 that cycle; next PC=0x120; RedirectCnt=1; MisalignErr=0.
- PC=0x020, ImemReady=0, PcSel=1, BrPC=0x40 -> DRAIN. ImemReady held 0 for 3 cycles, with a second PcSel with BrPC=0x80 during them. ImemReady=1 -> PC=0x80; FetchValid=0 throughout DRAIN; RedirectCnt=2.
- Stall=1 and PcSel=1 same cycle, BrPC=0x1F6, ImemReady=1 -> PC=0x1F4; MisalignErr=1 sticky; flushes asserted. Next cycle Stall=1, PcSel=0 -> PC held at 0x1F4.
- PC=508, ImemReady=1, no stall -> PC=0 next cycle; FetchValid=1.
- In DRAIN with PendPC=0x40, assert reset for 1 cycle -> PC=RESET_PC, state RUN, RedirectCnt=0, MisalignErr=0; the first fetch after reset is at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-side bundle between hazard/branch logic, instruction memory and the
// fetch redirect controller.
interface fetch_redirect_ctrl_if #(
  parameter int PC_W = 9
);
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            ImemReady;
  logic [PC_W-1:0] PC;
  logic            ImemReq;
  logic            FetchValid;
  logic            IfIdFlush;
  logic            IdExFlush;
  logic            MisalignErr;
  logic [15:0]     RedirectCnt;

  // Pipeline / memory side: drives control and ready, observes fetch state.
  modport master (
    output Stall, PcSel, BrPC, ImemReady,
    input  PC, ImemReq, FetchValid, IfIdFlush, IdExFlush, MisalignErr, RedirectCnt
  );

  // Controller side.
  modport slave (
    input  Stall, PcSel, BrPC, ImemReady,
    output PC, ImemReq, FetchValid, IfIdFlush, IdExFlush, MisalignErr, RedirectCnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: applies EX-stage redirects, drives the imem handshake and
// drops a stale in-flight access by draining it before switching PC.
//
// state   | meaning
// S_RUN   | normal fetch; PC advances on ImemReady unless stalled or redirected
// S_DRAIN | redirect arrived mid-access; hold old PC until memory finishes,
//         | then load the latest pending target
module fetch_redirect_ctrl #(
  parameter int PC_W     = 9,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_redirect_ctrl_if.slave bus
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pend_pc;
  logic            r_misalign;
  logic [15:0]     r_redirect_cnt;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pend_nxt;
  logic            w_fetch_valid;
  logic [PC_W-1:0] w_tgt;
  logic            w_misalign_tgt;
  logic            w_unused_brpc_hi;

  // Only the memory-addressable, word-aligned part of the target is used.
  assign w_tgt            = {bus.BrPC[PC_W-1:2], 2'b00};
  assign w_misalign_tgt   = |bus.BrPC[1:0];
  assign w_unused_brpc_hi = ^bus.BrPC[31:PC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_pc      <= RST_PC;
      r_pend_pc <= RST_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_nxt    = r_pend_pc;
    w_fetch_valid = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.PcSel) begin
          if (bus.ImemReady) begin
            w_pc_nxt = w_tgt;
          end else begin
            w_pend_nxt  = w_tgt;
            w_state_nxt = S_DRAIN;
          end
        end else if (!bus.Stall && bus.ImemReady) begin
          w_fetch_valid = 1'b1;
          w_pc_nxt      = r_pc + PC_W'(4);
        end
      end
      S_DRAIN: begin
        // Stall has no effect here: the old access must complete regardless.
        if (bus.PcSel) begin
          w_pend_nxt = w_tgt;
        end
        if (bus.ImemReady) begin
          w_pc_nxt    = bus.PcSel ? w_tgt : r_pend_pc;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign     <= 1'b0;
      r_redirect_cnt <= 16'h0000;
    end else if (bus.PcSel) begin
      if (w_misalign_tgt) begin
        r_misalign <= 1'b1;
      end
      if (r_redirect_cnt != 16'hFFFF) begin
        r_redirect_cnt <= r_redirect_cnt + 16'h0001;
      end
    end
  end

  // Handshake and flush outputs are forced low while reset is held.
  assign bus.PC          = r_pc;
  assign bus.ImemReq     = ~reset;
  assign bus.FetchValid  = w_fetch_valid & ~reset;
  assign bus.IfIdFlush   = bus.PcSel & ~reset;
  assign bus.IdExFlush   = bus.PcSel & ~reset;
  assign bus.MisalignErr = r_misalign;
  assign bus.RedirectCnt = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scoreboard bench for fetch_redirect_ctrl: stimulus pushes the
// expected per-cycle view, a negedge monitor pops and compares.
module tb_fetch_redirect_ctrl;
  localparam int PC_W = 9;

  typedef struct {
    logic        stall;
    logic        pcsel;
    logic [31:0] brpc;
    logic        rdy;
    logic [8:0]  pc;
    logic        fv;
    logic        fl;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [8:0]  pc;
    logic        fv;
    logic        fl;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;

  fetch_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

  fetch_redirect_ctrl #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d actual=0x%0h expected=0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic stall, input logic pcsel, input logic [31:0] brpc,
                     input logic rdy, input logic [8:0] pc, input logic fv,
                     input logic fl, input logic mis, input logic [15:0] cnt);
    vec_t v;
    v.stall = stall; v.pcsel = pcsel; v.brpc = brpc; v.rdy = rdy;
    v.pc = pc; v.fv = fv; v.fl = fl; v.mis = mis; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive one vector just after the edge and log what the DUT must show.
  task automatic run_vecs();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.Stall     = vecs[i].stall;
      bus.PcSel     = vecs[i].pcsel;
      bus.BrPC      = vecs[i].brpc;
      bus.ImemReady = vecs[i].rdy;
      e.idx = i; e.pc = vecs[i].pc; e.fv = vecs[i].fv; e.fl = vecs[i].fl;
      e.mis = vecs[i].mis; e.cnt = vecs[i].cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  task automatic check_reset_outputs(input int tag);
    chk("rst_pc", tag, 32'(bus.PC), 32'h0);
    chk("rst_imemreq", tag, 32'(bus.ImemReq), 32'h0);
    chk("rst_fetchvalid", tag, 32'(bus.FetchValid), 32'h0);
    chk("rst_ifidflush", tag, 32'(bus.IfIdFlush), 32'h0);
    chk("rst_idexflush", tag, 32'(bus.IdExFlush), 32'h0);
    chk("rst_misalign", tag, 32'(bus.MisalignErr), 32'h0);
    chk("rst_cnt", tag, 32'(bus.RedirectCnt), 32'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("imemreq", mon_e.idx, 32'(bus.ImemReq), 32'h1);
      chk("pc", mon_e.idx, 32'(bus.PC), 32'(mon_e.pc));
      chk("fetchvalid", mon_e.idx, 32'(bus.FetchValid), 32'(mon_e.fv));
      chk("ifidflush", mon_e.idx, 32'(bus.IfIdFlush), 32'(mon_e.fl));
      chk("idexflush", mon_e.idx, 32'(bus.IdExFlush), 32'(mon_e.fl));
      chk("misalign", mon_e.idx, 32'(bus.MisalignErr), 32'(mon_e.mis));
      chk("redirectcnt", mon_e.idx, 32'(bus.RedirectCnt), 32'(mon_e.cnt));
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.Stall = 1'b0;
    bus.PcSel = 1'b1;
    bus.BrPC = 32'h40;
    bus.ImemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(1000);
    reset = 1'b0;

    //  stall pcsel brpc        rdy  pc     fv fl mis cnt
    for (int i = 0; i < 8; i++) add(0, 0, 32'h0, 1, 9'(4 * i), 1, 0, 0, 16'd0);
    add(0, 1, 32'h0000_0040, 0, 9'h020, 0, 1, 0, 16'd0); // 8: RUN -> DRAIN
    add(0, 0, 32'h0,         0, 9'h020, 0, 0, 0, 16'd1);
    add(0, 1, 32'h0000_0080, 0, 9'h020, 0, 1, 0, 16'd1); // latest target wins
    add(1, 0, 32'h0,         0, 9'h020, 0, 0, 0, 16'd2); // stall ignored
    add(0, 0, 32'h0,         1, 9'h020, 0, 0, 0, 16'd2); // drain completes
    add(0, 1, 32'hFFFF_F120, 1, 9'h080, 0, 1, 0, 16'd2); // upper bits ignored
    add(1, 1, 32'h0000_01F6, 1, 9'h120, 0, 1, 0, 16'd3); // PcSel beats Stall
    add(1, 0, 32'h0,         1, 9'h1F4, 0, 0, 1, 16'd4);
    add(0, 0, 32'h0,         1, 9'h1F4, 1, 0, 1, 16'd4);
    add(0, 0, 32'h0,         1, 9'h1F8, 1, 0, 1, 16'd4);
    add(0, 0, 32'h0,         1, 9'h1FC, 1, 0, 1, 16'd4); // wraps to 0
    add(0, 0, 32'h0,         1, 9'h000, 1, 0, 1, 16'd4);
    add(0, 0, 32'h0,         0, 9'h004, 0, 0, 1, 16'd4);
    add(0, 1, 32'h0000_0040, 0, 9'h004, 0, 1, 1, 16'd4); // -> DRAIN
    add(0, 1, 32'h0000_0100, 1, 9'h004, 0, 1, 1, 16'd5); // same-cycle target
    add(0, 1, 32'h0000_0040, 0, 9'h100, 0, 1, 1, 16'd6); // -> DRAIN, pend 0x40
    add(0, 0, 32'h0,         0, 9'h100, 0, 0, 1, 16'd7);
    run_vecs();

    reset = 1'b1;
    bus.PcSel = 1'b1;
    bus.ImemReady = 1'b1;
    #1;
    check_reset_outputs(2000);
    @(posedge clk);
    #1;
    check_reset_outputs(2001);
    reset = 1'b0;

    add(0, 0, 32'h0, 1, 9'h000, 1, 0, 0, 16'd0);
    add(0, 0, 32'h0, 1, 9'h004, 1, 0, 0, 16'd0);
    add(0, 0, 32'h0, 1, 9'h008, 1, 0, 0, 16'd0);
    run_vecs();

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
